// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM-stage data-bus master with MEM/WB register, ack timeout and stall generation.
// Define MEM_MISALIGN_CHECK_EN to reject word-misaligned accesses without touching the bus.
module mem_stage_ctrl #(
  parameter int WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Zero_out,
  input  logic [31:0] ALU_result_out,
  input  logic [31:0] AddSum_out,
  input  logic [31:0] mux22_out_out,
  input  logic [4:0]  RD_EX_out,
  input  logic        MemRead_MEM,
  input  logic        MemtoReg_MEM,
  input  logic        MemWrite_MEM,
  input  logic        RegWrite_MEM,
  input  logic        Branch_MEM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic        PCSrc,
  output logic [31:0] branch_target,
  output logic [31:0] ReadData_WB,
  output logic [31:0] ALU_result_WB,
  output logic [4:0]  RD_WB,
  output logic        RegWrite_WB,
  output logic        MemtoReg_WB,
  output logic        bus_err,
  output logic        misalign_err
);
  localparam int CW = $clog2(WAIT_MAX + 1);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic r_req, r_we, r_to, r_mis;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [31:0] r_rd_wb, r_alu_wb;
  logic [4:0] r_rdst_wb;
  logic r_rw_wb, r_mtr_wb;
  logic w_memop, w_mis, w_issue, w_ack, w_to, w_resp;
  assign w_memop = MemRead_MEM | MemWrite_MEM;
`ifdef MEM_MISALIGN_CHECK_EN
  assign w_mis = w_memop && ALU_result_out[1:0] != 2'b00;
  assign misalign_err = w_resp && r_mis;
`else
  assign w_mis = 1'b0;
  assign misalign_err = 1'b0;
`endif
  assign w_issue = r_state == IDLE && w_memop;
  assign w_ack = r_state == ACCESS && dmem_ack;
  assign w_to = r_state == ACCESS && !dmem_ack && r_cnt == CW'(WAIT_MAX - 1);
  assign w_resp = r_state == RESP;
  assign PCSrc = Branch_MEM & Zero_out;
  assign branch_target = AddSum_out;
  assign bus_err = w_resp && r_to;
  assign dmem_req = r_req;
  assign dmem_we = r_we;
  assign dmem_addr = r_addr;
  assign dmem_wdata = r_wdata;
  assign ReadData_WB = r_rd_wb;
  assign ALU_result_WB = r_alu_wb;
  assign RD_WB = r_rdst_wb;
  assign RegWrite_WB = r_rw_wb;
  assign MemtoReg_WB = r_mtr_wb;
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    stall = w_issue || r_state == ACCESS;
    w_next = w_resp ? IDLE : w_issue ? (w_mis ? RESP : ACCESS) : (w_ack || w_to) ? RESP : r_state;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_cnt <= '0;
      r_req <= 1'b0;
      r_we <= 1'b0;
      r_to <= 1'b0;
      r_mis <= 1'b0;
      r_addr <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_rd_wb <= '0;
      r_alu_wb <= '0;
      r_rdst_wb <= '0;
      r_rw_wb <= 1'b0;
      r_mtr_wb <= 1'b0;
    end else begin
      if (w_issue) begin
        r_cnt <= '0;
        r_rdata <= '0;
        r_to <= 1'b0;
        r_mis <= w_mis;
        if (!w_mis) begin
          r_req <= 1'b1;
          r_we <= MemWrite_MEM;
          r_addr <= ALU_result_out;
          r_wdata <= mux22_out_out;
        end
      end
      if (w_ack) begin
        r_req <= 1'b0;
        if (!r_we) r_rdata <= dmem_rdata;
      end else if (w_to) begin
        r_req <= 1'b0;
        r_to <= 1'b1;
      end else if (r_state == ACCESS) r_cnt <= r_cnt + 1'b1;
      // Faulted accesses still retire through MEM/WB, but must not write the register file.
      r_alu_wb <= stall ? '0 : ALU_result_out;
      r_rdst_wb <= stall ? '0 : RD_EX_out;
      r_mtr_wb <= !stall && MemtoReg_MEM;
      r_rw_wb <= !stall && RegWrite_MEM && !(w_resp && (r_to || r_mis));
      r_rd_wb <= (!stall && w_resp) ? r_rdata : '0;
    end
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: directed and randomized checks of mem_stage_ctrl against a per-instruction latency/result model.
module tb_mem_stage_ctrl;
  localparam int WAIT_MAX = 15;
`ifdef MEM_MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b0;
  logic Zero_out = 1'b0, MemRead_MEM = 1'b0, MemtoReg_MEM = 1'b0, MemWrite_MEM = 1'b0;
  logic RegWrite_MEM = 1'b0, Branch_MEM = 1'b0, dmem_ack = 1'b0;
  logic [31:0] ALU_result_out = '0, AddSum_out = '0, mux22_out_out = '0, dmem_rdata = '0;
  logic [4:0] RD_EX_out = '0;
  logic dmem_req, dmem_we, stall, PCSrc, RegWrite_WB, MemtoReg_WB, bus_err, misalign_err;
  logic [31:0] dmem_addr, dmem_wdata, branch_target, ReadData_WB, ALU_result_WB;
  logic [4:0] RD_WB;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  mem_stage_ctrl #(.WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .reset(reset), .Zero_out(Zero_out), .ALU_result_out(ALU_result_out),
    .AddSum_out(AddSum_out), .mux22_out_out(mux22_out_out), .RD_EX_out(RD_EX_out),
    .MemRead_MEM(MemRead_MEM), .MemtoReg_MEM(MemtoReg_MEM), .MemWrite_MEM(MemWrite_MEM),
    .RegWrite_MEM(RegWrite_MEM), .Branch_MEM(Branch_MEM), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .stall(stall), .PCSrc(PCSrc), .branch_target(branch_target),
    .ReadData_WB(ReadData_WB), .ALU_result_WB(ALU_result_WB), .RD_WB(RD_WB),
    .RegWrite_WB(RegWrite_WB), .MemtoReg_WB(MemtoReg_WB), .bus_err(bus_err),
    .misalign_err(misalign_err)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // One instruction held on EX/MEM until it retires; the bus answers ack_at req-cycles in (0 = never).
  task automatic run_op(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input logic [4:0] rdst, input bit regw, input bit mtr,
                        input bit br, input bit zr, input logic [31:0] tgt, input int ack_at, input bit noise);
    bit memop, mis, to;
    int n_acc, exp_st, st, reqc;
    logic [31:0] exp_rd;
    memop = rd | wr;
    mis = MIS_EN && memop && addr[1:0] != 2'b00;
    to = memop && !mis && (ack_at < 1 || ack_at > WAIT_MAX);
    n_acc = (!memop || mis) ? 0 : (to ? WAIT_MAX : ack_at);
    exp_st = memop ? 1 + n_acc : 0;
    exp_rd = (rd && !wr && memop && !mis && !to) ? rdata : 32'h0;
    MemRead_MEM = rd; MemWrite_MEM = wr; ALU_result_out = addr; mux22_out_out = wdata;
    RD_EX_out = rdst; RegWrite_MEM = regw; MemtoReg_MEM = mtr;
    Branch_MEM = br; Zero_out = zr; AddSum_out = tgt;
    st = 0; reqc = 0;
    for (int c = 0; c < 40; c++) begin
      if (dmem_req) reqc++;
      dmem_ack = dmem_req ? (reqc == ack_at) : noise;
      dmem_rdata = (dmem_req && reqc == ack_at) ? rdata : $urandom;
      #1;
      if (!stall) break;
      if (dmem_req) begin
        chk("bus_addr", dmem_addr, addr);
        chk("bus_wdata", dmem_wdata, wdata);
        chk("bus_we", dmem_we, wr);
      end
      if (st > 0) chk("bubble", ALU_result_WB | ReadData_WB | 32'({RD_WB, RegWrite_WB, MemtoReg_WB}), 0);
      st++;
      @(negedge clk);
    end
    chk("stall_cycles", st, exp_st);
    chk("req_cycles", reqc, n_acc);
    chk("bus_err", bus_err, to);
    chk("misalign_err", misalign_err, mis);
    chk("pcsrc", PCSrc, br & zr);
    chk("branch_target", branch_target, tgt);
    @(negedge clk);
    dmem_ack = 1'b0;
    chk("wb_alu", ALU_result_WB, addr);
    chk("wb_rd", RD_WB, rdst);
    chk("wb_regwrite", RegWrite_WB, regw && !to && !mis);
    chk("wb_memtoreg", MemtoReg_WB, mtr);
    chk("wb_readdata", ReadData_WB, exp_rd);
  endtask
  initial begin
    int kind, r, ack_at;
    #2 reset = 1'b1;
    #1;
    chk("rst_req", dmem_req, 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_wb", ALU_result_WB | ReadData_WB | 32'({RD_WB, RegWrite_WB, MemtoReg_WB}), 0);
    chk("rst_stall", stall, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    run_op(1, 0, 32'h100, 32'h0, 32'hDEADBEEF, 5'd5, 1, 1, 0, 0, 32'h0, 1, 0);
    run_op(0, 1, 32'h200, 32'h12345678, 32'hCAFEF00D, 5'd7, 0, 0, 0, 0, 32'h0, 4, 1);
    run_op(1, 0, 32'h300, 32'h0, 32'h11111111, 5'd9, 1, 1, 0, 0, 32'h0, 0, 0);
    run_op(0, 0, 32'h55, 32'h0, 32'h0, 5'd3, 1, 0, 1, 1, 32'h40, 1, 1);
    run_op(1, 1, 32'h404, 32'hA5A5A5A5, 32'h77777777, 5'd4, 1, 0, 0, 0, 32'h0, 2, 0);
    run_op(1, 0, 32'h102, 32'h0, 32'h22222222, 5'd6, 1, 1, 0, 0, 32'h0, 1, 0);
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 3);
      r = $urandom_range(0, 9);
      ack_at = r == 0 ? 0 : r == 9 ? WAIT_MAX + 1 : r;
      run_op(kind[0], kind[1], $urandom_range(0, 3) == 0 ? $urandom : ($urandom & 32'hFFFF_FFFC),
             $urandom, $urandom, 5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom), $urandom, ack_at, 1'($urandom));
    end
    MemRead_MEM = 1'b1; MemWrite_MEM = 1'b0; ALU_result_out = 32'h500; RegWrite_MEM = 1'b1;
    for (int c = 0; c < 5 && !dmem_req; c++) @(negedge clk);
    chk("pre_rst_req", dmem_req, 1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_rst_req", dmem_req, 0);
    chk("mid_rst_addr", dmem_addr, 0);
    chk("mid_rst_stall", stall, 1);
    dmem_ack = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    run_op(1, 0, 32'h600, 32'h0, 32'h0BADCAFE, 5'd8, 1, 1, 0, 0, 32'h0, 1, 1);
    run_op(1, 0, 32'h604, 32'h0, 32'h13579BDF, 5'd9, 1, 1, 0, 0, 32'h0, 2, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_stage_ctrl.md
MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 The block SHALL have parameter WAIT_MAX, default 15: the maximum number of ACCESS cycles spent waiting for dmem_ack before a timeout.
REQ-002 The block SHALL have these ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- Zero_out  in  1  ALU zero flag from EX/MEM.
- ALU_result_out  in  32  memory address or ALU result from EX/MEM.
- AddSum_out  in  32  branch target from EX/MEM.
- mux22_out_out  in  32  store data from EX/MEM.
- RD_EX_out  in  5  destination register from EX/MEM.
- MemRead_MEM, MemtoReg_MEM, MemWrite_MEM, RegWrite_MEM, Branch_MEM  in  1 each  control bits from EX/MEM.
- dmem_req  out  1  bus request.
- dmem_we  out  1  write enable.
- dmem_addr  out  32  bus address.
- dmem_wdata  out  32  bus write data.
- dmem_ack  in  1  bus completion.
- dmem_rdata  in  32  bus read data.
- stall  out  1  freezes PC, IF/ID, ID/EX and EX/MEM.
- PCSrc  out  1  branch taken.
- branch_target  out  32  next PC when PCSrc is 1.
- ReadData_WB  out  32  MEM/WB load data.
- ALU_result_WB  out  32  MEM/WB ALU result.
- RD_WB  out  5  MEM/WB destination register.
- RegWrite_WB, MemtoReg_WB  out  1 each  MEM/WB control bits.
- bus_err  out  1  one-cycle timeout pulse.
- misalign_err  out  1  one-cycle misaligned-access pulse.

Function
REQ-003 PCSrc SHALL equal Branch_MEM AND Zero_out, and branch_target SHALL equal AddSum_out; both are combinational and independent of the state machine.
REQ-004 The state machine SHALL have three states, IDLE, ACCESS and RESP, and SHALL start in IDLE.
REQ-005 A memory op is MemRead_MEM or MemWrite_MEM being high; in IDLE a memory op SHALL cause the next state to be ACCESS.
REQ-006 On that IDLE-to-ACCESS edge, the block SHALL register dmem_req=1, dmem_addr=ALU_result_out, dmem_wdata=mux22_out_out and dmem_we=MemWrite_MEM.
REQ-007 If MemRead_MEM and MemWrite_MEM are both high, the block SHALL perform a write and SHALL set ReadData_WB to 0.
REQ-008 In ACCESS, dmem_req, dmem_we, dmem_addr and dmem_wdata SHALL stay stable until dmem_ack is sampled high.
REQ-009 When dmem_ack is sampled high in ACCESS, the block SHALL capture dmem_rdata (reads only), drop dmem_req and go to RESP.
REQ-010 A wait counter SHALL clear on entering ACCESS and increment on each ACCESS cycle without ack.
REQ-011 When the wait counter reaches WAIT_MAX, the block SHALL drop dmem_req, capture 0 as read data, pulse bus_err during RESP, force RegWrite_WB to 0 for that instruction, and go to RESP.
REQ-012 dmem_ack SHALL be ignored in IDLE and RESP.
REQ-013 RESP SHALL last exactly one cycle and SHALL return to IDLE.
REQ-014 stall SHALL be combinational and equal (IDLE AND memory op) OR ACCESS; it SHALL be 0 in RESP.
REQ-015 Minimum memory-op latency SHALL be 3 cycles (IDLE, ACCESS with ack, RESP), giving 2 stall cycles; each extra ack-wait cycle SHALL add 1 stall cycle.
REQ-016 MEM/WB outputs SHALL load at every rising edge where stall=0: ALU_result_WB=ALU_result_out, RD_WB=RD_EX_out, RegWrite_WB=RegWrite_MEM, MemtoReg_WB=MemtoReg_MEM, ReadData_WB=captured data (0 for non-memory ops).
REQ-017 At every rising edge where stall=1, MEM/WB outputs SHALL load a bubble: all fields 0.
REQ-018 A non-memory instruction SHALL pass through in 1 cycle with no stall.

Reset
REQ-019 Assertion of reset SHALL immediately, without waiting for a clock edge, set the state to IDLE, clear the wait counter, and drive every registered output to 0, including dmem_req during an ACCESS.
REQ-020 After reset deasserts, the first memory op SHALL start a fresh transaction, and any pending dmem_ack SHALL be ignored.

Configuration
REQ-021 Macro MEM_MISALIGN_CHECK_EN SHALL control misaligned-access checking.
REQ-022 With MEM_MISALIGN_CHECK_EN defined, a memory op in IDLE with ALU_result_out[1:0] not equal to 0 SHALL go directly to RESP without asserting dmem_req, pulse misalign_err during RESP, and force RegWrite_WB to 0.
REQ-023 Without MEM_MISALIGN_CHECK_EN, misalign_err SHALL be tied to 0 and all addresses SHALL be issued unmodified.

Verification
REQ-024 Load at 0x100, dmem_ack 1 cycle after req, rdata 0xDEADBEEF, RD=5, RegWrite=1, MemtoReg=1 -> stall high 2 cycles, then ReadData_WB=0xDEADBEEF, RD_WB=5.
REQ-025 Store 0x12345678 to 0x200, ack after 4 wait cycles -> addr/wdata/we stable throughout, stall high 5 cycles, RegWrite_WB=0.
REQ-026 Load, ack never arrives, WAIT_MAX=15 -> dmem_req drops after 15 ACCESS cycles, bus_err pulses once, ReadData_WB=0, RegWrite_WB=0.
REQ-027 Branch_MEM=1, Zero_out=1, AddSum_out=0x40 -> PCSrc=1 and branch_target=0x40 in the same cycle, with stall=0.
REQ-028 reset asserted mid-ACCESS -> dmem_req goes to 0 immediately; after deassertion, a back-to-back load completes normally.
REQ-029 With MEM_MISALIGN_CHECK_EN defined, load at 0x102 -> no dmem_req, misalign_err pulses once, RegWrite_WB=0, 1 stall cycle.
